// File: rtl/decode_regread.sv
// Y86-64 decode stage: 15-entry register file with two writeback ports, write-first
// bypass to the source reads, and a single registered output stage toward execute.
module decode_regread #(
  parameter int WIDTH   = 64,
  parameter int NREGS   = 15,
  parameter int RSP_IDX = 4
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             in_valid,
  input  logic             stall,
  input  logic [3:0]       in_code,
  input  logic [3:0]       ra,
  input  logic [3:0]       rb,
  input  logic             we_e,
  input  logic [3:0]       dst_e,
  input  logic [WIDTH-1:0] val_e,
  input  logic             we_m,
  input  logic [3:0]       dst_m,
  input  logic [WIDTH-1:0] val_m,
  output logic             out_valid,
  output logic [3:0]       src_a,
  output logic [3:0]       src_b,
  output logic [WIDTH-1:0] val_a,
  output logic [WIDTH-1:0] val_b,
  output logic             accepted
);

  localparam logic [3:0] RNONE = 4'hF;
  localparam logic [3:0] RSP   = 4'(RSP_IDX);

  logic [WIDTH-1:0] regs [NREGS];
  logic [3:0]       src_a_d, src_b_d;
  logic [WIDTH-1:0] rd_a, rd_b;

  // Handshake: a decode is taken on a rising edge when in_valid && !stall; stall
  // freezes the whole output stage, and without in_valid only out_valid drops.
  assign accepted = in_valid && !stall;

  always_comb begin
    src_a_d = RNONE;
    src_b_d = RNONE;
    case (in_code)
      4'h2: src_a_d = ra;
      4'h4: begin src_a_d = ra;  src_b_d = rb;  end
      4'h5: src_b_d = rb;
      4'h6: begin src_a_d = ra;  src_b_d = rb;  end
      4'h8: src_b_d = RSP;
      4'h9: begin src_a_d = RSP; src_b_d = RSP; end
      4'hA: begin src_a_d = ra;  src_b_d = RSP; end
      4'hB: begin src_a_d = RSP; src_b_d = RSP; end
      default: ;
    endcase
  end

  // Reads see this cycle's writes; M is checked last so it wins over E.
  always_comb begin
    rd_a = '0;
    if (src_a_d != RNONE) begin
      rd_a = regs[src_a_d];
      if (we_e && dst_e == src_a_d) rd_a = val_e;
      if (we_m && dst_m == src_a_d) rd_a = val_m;
    end
  end

  always_comb begin
    rd_b = '0;
    if (src_b_d != RNONE) begin
      rd_b = regs[src_b_d];
      if (we_e && dst_e == src_b_d) rd_b = val_e;
      if (we_m && dst_m == src_b_d) rd_b = val_m;
    end
  end

  // The M write is issued after E so a same-index collision stores val_m.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < NREGS; i++) regs[i] <= '0;
    end else begin
      if (we_e && dst_e != RNONE) regs[dst_e] <= val_e;
      if (we_m && dst_m != RNONE) regs[dst_m] <= val_m;
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      out_valid <= 1'b0;
      src_a     <= RNONE;
      src_b     <= RNONE;
      val_a     <= '0;
      val_b     <= '0;
    end else if (accepted) begin
      out_valid <= 1'b1;
      src_a     <= src_a_d;
      src_b     <= src_b_d;
      val_a     <= rd_a;
      val_b     <= rd_b;
    end else if (!stall) begin
      out_valid <= 1'b0;
    end
  end

endmodule

// File: tb/tb_decode_regread.sv
// Bench for decode_regread: directed scenarios plus random traffic, all checked
// against a register-file model that applies writes and then reads.
module tb_decode_regread;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        in_valid = 1'b0, stall = 1'b0;
  logic [3:0]  in_code = '0, ra = '0, rb = '0;
  logic        we_e = 1'b0, we_m = 1'b0;
  logic [3:0]  dst_e = '0, dst_m = '0;
  logic [63:0] val_e = '0, val_m = '0;
  logic        out_valid, accepted;
  logic [3:0]  src_a, src_b;
  logic [63:0] val_a, val_b;

  int n_tests = 0;
  int n_fail  = 0;

  logic [63:0] m_regs [16];
  logic        e_valid;
  logic [3:0]  e_src_a, e_src_b;
  logic [63:0] e_val_a, e_val_b;

  decode_regread dut (
    .clock(clock), .reset_n(reset_n), .in_valid(in_valid), .stall(stall),
    .in_code(in_code), .ra(ra), .rb(rb),
    .we_e(we_e), .dst_e(dst_e), .val_e(val_e),
    .we_m(we_m), .dst_m(dst_m), .val_m(val_m),
    .out_valid(out_valid), .src_a(src_a), .src_b(src_b),
    .val_a(val_a), .val_b(val_b), .accepted(accepted)
  );

  always #5 clock = ~clock;

  task automatic model_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = '0;
    e_valid = 1'b0; e_src_a = 4'hF; e_src_b = 4'hF; e_val_a = '0; e_val_b = '0;
  endtask

  // Source table: which fields each instruction reads.
  function automatic logic [7:0] ref_srcs(input logic [3:0] c, input logic [3:0] a, input logic [3:0] b);
    case (c)
      4'h2: return {a, 4'hF};
      4'h4: return {a, b};
      4'h5: return {4'hF, b};
      4'h6: return {a, b};
      4'h8: return {4'hF, 4'h4};
      4'h9: return {4'h4, 4'h4};
      4'hA: return {a, 4'h4};
      4'hB: return {4'h4, 4'h4};
      default: return 8'hFF;
    endcase
  endfunction

  task automatic drive(input logic iv, input logic st, input logic [3:0] c, input logic [3:0] a,
                       input logic [3:0] b, input logic wee, input logic [3:0] de, input logic [63:0] ve,
                       input logic wem, input logic [3:0] dm, input logic [63:0] vm);
    in_valid = iv; stall = st; in_code = c; ra = a; rb = b;
    we_e = wee; dst_e = de; val_e = ve; we_m = wem; dst_m = dm; val_m = vm;
  endtask

  task automatic check_outputs(input string name);
    n_tests++;
    if (out_valid !== e_valid) begin n_fail++; $display("FAIL %s out_valid got %0b exp %0b", name, out_valid, e_valid); end
    n_tests++;
    if (src_a !== e_src_a) begin n_fail++; $display("FAIL %s src_a got %h exp %h", name, src_a, e_src_a); end
    n_tests++;
    if (src_b !== e_src_b) begin n_fail++; $display("FAIL %s src_b got %h exp %h", name, src_b, e_src_b); end
    n_tests++;
    if (val_a !== e_val_a) begin n_fail++; $display("FAIL %s val_a got %h exp %h", name, val_a, e_val_a); end
    n_tests++;
    if (val_b !== e_val_b) begin n_fail++; $display("FAIL %s val_b got %h exp %h", name, val_b, e_val_b); end
  endtask

  // One clock: model the edge with the currently driven inputs, then compare.
  task automatic step(input string name);
    logic [63:0] nr [16];
    logic [7:0]  s;
    logic        acc;
    #1;
    acc = in_valid && !stall;
    n_tests++;
    if (accepted !== acc) begin n_fail++; $display("FAIL %s accepted got %0b exp %0b", name, accepted, acc); end
    nr = m_regs;
    if (we_e && dst_e != 4'hF) nr[dst_e] = val_e;
    if (we_m && dst_m != 4'hF) nr[dst_m] = val_m;
    if (acc) begin
      s = ref_srcs(in_code, ra, rb);
      e_valid = 1'b1;
      e_src_a = s[7:4];
      e_src_b = s[3:0];
      e_val_a = nr[s[7:4]];
      e_val_b = nr[s[3:0]];
    end else if (!stall) begin
      e_valid = 1'b0;
    end
    m_regs = nr;
    @(posedge clock);
    #1;
    check_outputs(name);
  endtask

  task automatic read_all(input string name);
    for (int i = 0; i < 15; i += 2) begin
      drive(1, 0, 4'h6, 4'(i), 4'((i + 1) % 15), 0, 0, 0, 0, 0, 0);
      step(name);
    end
  endtask

  task automatic test_reset();
    drive(1, 0, 4'h6, 4'h1, 4'h2, 1, 4'h1, 64'hDEAD, 1, 4'h2, 64'hBEEF);
    step("pre_reset");
    @(posedge clock);
    #3;
    reset_n = 1'b0;
    drive(1, 0, 4'h6, 4'h1, 4'h2, 1, 4'h3, 64'h5555, 0, 0, 0);
    #1;
    model_reset();
    check_outputs("reset_async");
    @(negedge clock);
    reset_n = 1'b1;
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    @(posedge clock);
    #1;
    read_all("reset_regs");
  endtask

  task automatic test_write_read();
    drive(0, 0, 0, 0, 0, 1, 4'h3, 64'h1122, 0, 0, 0);
    step("wr_write");
    drive(1, 0, 4'h6, 4'h3, 4'h3, 0, 0, 0, 0, 0, 0);
    step("wr_read");
    n_tests++;
    if (val_a !== 64'h1122 || val_b !== 64'h1122 || out_valid !== 1'b1) begin
      n_fail++; $display("FAIL wr_const val_a %h val_b %h ov %0b exp 1122 1122 1", val_a, val_b, out_valid);
    end
  endtask

  task automatic test_bypass();
    drive(0, 0, 0, 0, 0, 1, 4'h7, 64'h77, 0, 0, 0);
    step("byp_prep");
    drive(1, 0, 4'h4, 4'h2, 4'h7, 0, 0, 0, 1, 4'h2, 64'hAB);
    step("byp_m");
    n_tests++;
    if (val_a !== 64'hAB || val_b !== 64'h77) begin
      n_fail++; $display("FAIL byp_const val_a %h val_b %h exp ab 77", val_a, val_b);
    end
    drive(1, 0, 4'h6, 4'h5, 4'h5, 1, 4'h5, 64'h5E, 0, 0, 0);
    step("byp_e");
  endtask

  task automatic test_collision();
    drive(0, 0, 0, 0, 0, 1, 4'h4, 64'h5, 1, 4'h4, 64'h9);
    step("col_write");
    drive(1, 0, 4'h9, 0, 0, 0, 0, 0, 0, 0, 0);
    step("col_read");
    n_tests++;
    if (val_a !== 64'h9 || val_b !== 64'h9) begin
      n_fail++; $display("FAIL col_const val_a %h val_b %h exp 9 9", val_a, val_b);
    end
    drive(1, 0, 4'hB, 0, 0, 1, 4'h4, 64'h11, 1, 4'h4, 64'h22);
    step("col_bypass");
  endtask

  task automatic test_rnone();
    drive(1, 0, 4'h3, 4'hF, 4'h1, 0, 0, 0, 0, 0, 0);
    step("rnone_dec");
    n_tests++;
    if (src_a !== 4'hF || src_b !== 4'hF || val_a !== 0 || val_b !== 0) begin
      n_fail++; $display("FAIL rnone_const src %h %h val %h %h exp f f 0 0", src_a, src_b, val_a, val_b);
    end
    drive(1, 0, 4'h6, 4'hF, 4'h3, 1, 4'hF, 64'hFFFF, 1, 4'hF, 64'hEEEE);
    step("rnone_wr");
    read_all("rnone_regs");
  endtask

  task automatic test_stall();
    drive(1, 0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_load");
    for (int k = 0; k < 3; k++) begin
      drive(1, 1, 4'h6, 4'h1, 4'h2, 1, 4'h4, 64'h7, 0, 0, 0);
      step("stall_hold");
    end
    drive(1, 0, 4'h8, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_release");
    n_tests++;
    if (val_b !== 64'h7) begin n_fail++; $display("FAIL stall_const val_b %h exp 7", val_b); end
    drive(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("stall_idle_hold");
    drive(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
    step("idle_drop");
  endtask

  task automatic test_random();
    for (int n = 0; n < 400; n++) begin
      drive($urandom_range(0, 3) != 0, $urandom_range(0, 4) == 0, 4'($urandom_range(0, 15)),
            4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)),
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), {$urandom, $urandom},
            $urandom_range(0, 1) == 1, 4'($urandom_range(0, 15)), {$urandom, $urandom});
      step("random");
    end
  endtask

  initial begin
    model_reset();
    repeat (2) @(posedge clock);
    #1;
    check_outputs("reset_init");
    @(negedge clock);
    reset_n = 1'b1;
    @(posedge clock);
    #1;
    test_reset();
    test_write_read();
    test_bypass();
    test_collision();
    test_rnone();
    test_stall();
    test_random();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
